serial_subtractor_nbit: RTL and testbench

SERIAL_SUBTRACTOR_NBIT -- requirements
Module: serial_subtractor_nbit

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor_1bit.sv | 13 +
 rtl/serial_subtractor_nbit.sv | 113 +++++++++++
 tb/tb_serial_subtractor_nbit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int NUM_BITS_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: diff = a - b - borrow_in, with outgoing borrow.
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: one LSB-first bit per SHIFT cycle, result
// published on entry to DONE, done pulse registered one cycle later.
module serial_subtractor_nbit
  import serial_sub_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_BITS-1:0] r_a;
  logic [NUM_BITS-1:0] r_b;
  logic [NUM_BITS-2:0] r_res;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_br;
  logic                r_busy;
  logic                r_done;
  logic [NUM_BITS-1:0] r_diff;
  logic                r_borrow_out;

  logic                w_d;
  logic                w_br_nxt;
  logic                w_last;
  logic [NUM_BITS-1:0] w_full;

  full_subtractor_1bit u_fs (
    .a          (r_a[0]),
    .b          (r_b[0]),
    .borrow_in  (r_br),
    .diff       (w_d),
    .borrow_out (w_br_nxt)
  );

  assign w_last = (r_cnt == CNT_W'(NUM_BITS - 1));

  // The result register is one bit short: the final d completes the word
  // directly into diff, so no stale bit is ever carried.
  assign w_full = {w_d, r_res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_cnt        <= '0;
      r_br         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_SHIFT);
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= borrow_in;
            r_cnt <= '0;
            r_res <= '0;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + 1'b1;
          r_res <= w_full[NUM_BITS-1:1];
          if (w_last) begin
            r_diff       <= w_full;
            r_borrow_out <= w_br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Scoreboard bench for serial_subtractor_nbit: expected {borrow,diff} queued
// at issue, popped and compared by a monitor on every done pulse.
module tb_serial_subtractor_nbit;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;

  logic [N:0]   sb[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  int           n_done = 0;

  always #5 clk = ~clk;

  serial_subtractor_nbit #(.NUM_BITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (bout)
  );

  // Reference: plain integer subtraction, truncated to N+1 bits.
  function automatic logic [N:0] model(input int ua, input int ub, input int ubi);
    return (N+1)'(ua - ub - ubi);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      logic [N:0] e;
      n_done++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got {bout,diff}=%0h expected no done at %0t",
                 {bout, diff}, $time);
      end else begin
        e = sb.pop_front();
        if ({bout, diff} !== e) begin
          n_fail++;
          $display("FAIL result: got {bout,diff}=%0h expected %0h at %0t",
                   {bout, diff}, e, $time);
        end
      end
    end
  end

  // Called just after a clock edge with the DUT idle; returns just after an
  // edge with the DUT idle again.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tbv,
                       input logic tbi, input logic poke);
    int k;
    int nb;
    int d0;
    d0 = n_done;
    a = ta; b = tbv; bin = tbi; start = 1'b1;
    sb.push_back(model(ta, tbv, tbi));
    @(posedge clk); #1;
    start = 1'b0;
    a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
    nb = busy ? 1 : 0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (busy) nb++;
      if (done) break;
      start = poke && (k == 1);
      a = start ? N'(1) : N'($urandom);
      b = start ? N'(2) : N'($urandom);
      bin = 1'($urandom);
    end
    start = 1'b0;
    chk("latency", k, N + 1);
    chk("busy_cycles", nb, N);
    @(posedge clk); #1;
    chk("done_width", {31'd0, done}, 0);
    chk("done_count", n_done - d0, 1);
  endtask

  initial begin
    int         ord[512];
    int         j;
    int         t;
    int         d0;
    logic [8:0] c;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_diff", {28'd0, diff}, 0);
    chk("rst_bout", {31'd0, bout}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(4'd9, 4'd3, 1'b0, 1'b0);
    do_op(4'd3, 4'd9, 1'b0, 1'b0);
    do_op(4'd0, 4'd0, 1'b1, 1'b0);
    do_op(4'd9, 4'd3, 1'b0, 1'b1);

    // Abort during the second SHIFT cycle; no result may appear.
    d0 = n_done;
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_diff", {28'd0, diff}, 0);
    chk("abort_bout", {31'd0, bout}, 0);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    do_op(4'd15, 4'd15, 1'b0, 1'b0);

    // start held high: new op accepted every N+2 cycles.
    d0 = n_done;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
      sb.push_back(model(a, b, bin));
      repeat (N + 2) @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_done_count", n_done - d0, 4);

    for (int i = 0; i < 512; i++) ord[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      c = 9'(ord[i]);
      do_op(c[3:0], c[7:4], c[8], 1'b0);
    end

    for (int i = 0; i < 40; i++)
      do_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
